pipe_reg_chain: RTL and testbench

- Parametrised successor of the single D-FF: a chain of DEPTH registers, each WIDTH bits, with valid/ready flow control.
- Each stage holds data plus a valid bit. Bubbles collapse, so an empty stage accepts new data even while downstream stages are stalled.
- Used as a retiming/latency-balancing pipe between streaming blocks.
- Also provides a synchronous flush of all in-flight data.

---
 rtl/pipe_reg_chain.sv | 109 ++++++++++
 tb/tb_pipe_reg_chain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipe with collapsing bubbles and synchronous flush.
// Define PIPE_REG_CHAIN_COUNT_EN to add the registered occupancy output count_o.
module pipe_reg_chain #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
`ifdef PIPE_REG_CHAIN_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d  [DEPTH];
  logic [DEPTH:0]   adv;

  // A stage may advance when it is empty or the stage after it is moving.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid_i;
    src_d[0] = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = valid_q[k-1];
      src_d[k] = data_q[k-1];
    end
  end

  // Flush only clears valids; data registers keep their contents.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i) begin
        valid_d[k] = 1'b0;
      end else if (adv[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = src_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_DATA;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready_o  = adv[0] && !flush_i;
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Registered popcount of the next-state valids, so it tracks valid_q exactly.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=3, RST_DATA=0).
// Occupancy checks are compiled in only with PIPE_REG_CHAIN_COUNT_EN.
module tb_pipe_reg_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef PIPE_REG_CHAIN_COUNT_EN
  logic [CW-1:0]    count;
`endif

  int checks = 0;
  int errors = 0;

  pipe_reg_chain #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_DATA('0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready)
`ifdef PIPE_REG_CHAIN_COUNT_EN
    ,
    .count_o    (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic ordy, input logic fl, input logic rs);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input int expected);
`ifdef PIPE_REG_CHAIN_COUNT_EN
    checkOutput(tag, WIDTH'(count), WIDTH'(expected));
`endif
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 8'(out_valid), 8'h00);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_in_ready", 8'(in_ready), 8'h01);
    checkCount("rst_count", 0);

    // Streaming with downstream ready: 3-edge latency, no gaps.
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_not_yet", 8'(out_valid), 8'h00);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_v0", 8'(out_valid), 8'h01);
    checkOutput("stream_d0", out_data, 8'h11);
    tick();
    checkOutput("stream_v1", 8'(out_valid), 8'h01);
    checkOutput("stream_d1", out_data, 8'h22);
    tick();
    checkOutput("stream_d2", out_data, 8'h33);
    tick();
    checkOutput("stream_empty", 8'(out_valid), 8'h00);

    // Fill while stalled, then simultaneous pop and push.
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_ready0", 8'(in_ready), 8'h01);
    tick();
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    checkOutput("full_in_ready", 8'(in_ready), 8'h00);
    checkOutput("full_out_data", out_data, 8'hA1);
    checkCount("full_count", 3);
    tick();
    checkOutput("stall_hold_data", out_data, 8'hA1);
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
    checkOutput("poppush_in_ready", 8'(in_ready), 8'h01);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkCount("poppush_count", 3);
    checkOutput("order_a2", out_data, 8'hA2);
    tick();
    checkOutput("order_a3", out_data, 8'hA3);
    tick();
    checkOutput("order_a4_v", 8'(out_valid), 8'h01);
    checkOutput("order_a4", out_data, 8'hA4);
    tick();
    checkOutput("drain_empty", 8'(out_valid), 8'h00);

    // Bubble collapse while downstream is stalled.
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bubble_out_v", 8'(out_valid), 8'h01);
    checkOutput("bubble_out_d", out_data, 8'h55);
    checkOutput("bubble_in_ready", 8'(in_ready), 8'h01);
    checkCount("bubble_count", 2);
    tick();
    checkOutput("bubble_hold_d", out_data, 8'h55);
    checkCount("bubble_hold_count", 2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("bubble_next_d", out_data, 8'h66);
    checkOutput("bubble_next_v", 8'(out_valid), 8'h01);
    tick();
    checkOutput("bubble_drained", 8'(out_valid), 8'h00);

    // Flush of a full chain with a word offered in the flush cycle.
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB4, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_in_ready", 8'(in_ready), 8'h00);
    checkOutput("flush_out_valid", 8'(out_valid), 8'h01);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_v", 8'(out_valid), 8'h00);
    checkOutput("post_flush_data_kept", out_data, 8'hB1);
    checkOutput("post_flush_ready", 8'(in_ready), 8'h01);
    checkCount("post_flush_count", 0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checkOutput("no_flush_word", 8'(out_valid), 8'h00);
    end

    // Reset mid-stream with flush and a push, then latency after reset.
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_v", 8'(out_valid), 8'h00);
    checkOutput("midrst_d", out_data, 8'h00);
    checkOutput("midrst_ready", 8'(in_ready), 8'h01);
    checkCount("midrst_count", 0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_lat_e1", 8'(out_valid), 8'h00);
    tick();
    checkOutput("rst_lat_e2", 8'(out_valid), 8'h00);
    tick();
    checkOutput("rst_lat_v", 8'(out_valid), 8'h01);
    checkOutput("rst_lat_d", out_data, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
